// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths, FSM state encoding and PC-select codes for the fetch stage.
package pc_fetch_pkg;
   localparam int PC_W    = 5;
   localparam int INSTR_W = 32;
   localparam int WAIT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PCSEL_PC4   = 2'b00,
      PCSEL_CONST = 2'b01,
      PCSEL_REG   = 2'b10
   } pcsel_t;

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] p);
      return {p[PC_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory bus plus decode handshake.
//   master (fetch stage): drives imem_addr/imem_req/instr/instr_valid, takes imem_ack/imem_rdata/instr_ready
//   slave  (memory+decode): the mirror image
interface pc_fetch_if;
   import pc_fetch_pkg::*;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_req;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   modport master (
      output imem_addr, imem_req, instr, instr_valid,
      input  imem_ack, imem_rdata, instr_ready
   );
   modport slave (
      input  imem_addr, imem_req, instr, instr_valid,
      output imem_ack, imem_rdata, instr_ready
   );
endinterface

// File: rtl/pc_fetch_timer.sv
// fetch_timer: counts FETCH cycles without ack and flags a timeout.
//   clk, rst : clock, synchronous active-high reset
//   active   : FSM is in FETCH (counter held at 0 otherwise, so it is clear on FETCH entry)
//   ack      : memory acknowledged this cycle
//   expired  : TIMEOUT-th consecutive cycle without ack; counter restarts
module fetch_timer
   import pc_fetch_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic expired
);
   logic [WAIT_W-1:0] cnt_q, cnt_d;

   // The compare uses TIMEOUT-1 so the cycle that would bring the count to
   // TIMEOUT is the one that fires; an ack in that same cycle wins.
   always_comb begin
      expired = active && !ack && (cnt_q == WAIT_W'(TIMEOUT - 1));
      cnt_d   = (!active || ack || expired) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, instruction fetch FSM (IDLE/FETCH/VALID) and decode handoff.
//   clk, rst      : clock, synchronous active-high reset
//   pc_from_pcsel : next PC from the PC-select mux, loaded (word-aligned) on the decode handshake
//   const_off     : two's-complement branch offset
//   pc, pc_plus_4, pc_const : current PC and the two adder results (carry dropped)
//   bus           : instruction-memory request/ack and decode valid/ready
//   fetch_err     : sticky, a fetch timed out
//   misalign_err  : sticky, a non-word-aligned next PC was loaded
//   retired       : accepted-instruction count, wraps
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 5'd0,
   parameter int              TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_from_pcsel,
   input  logic [PC_W-1:0] const_off,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus_4,
   output logic [PC_W-1:0] pc_const,
   pc_fetch_if.master      bus,
   output logic            fetch_err,
   output logic            misalign_err,
   output logic [15:0]     retired
);
   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               fetch_err_q, fetch_err_d;
   logic               misalign_err_q, misalign_err_d;
   logic [15:0]        retired_q, retired_d;
   logic               in_fetch, got_ack, handshake, expired;

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .active  (in_fetch),
      .ack     (bus.imem_ack),
      .expired (expired)
   );

   always_comb begin
      in_fetch       = state_q == FETCH;
      got_ack        = in_fetch && bus.imem_ack;
      handshake      = state_q == VALID && bus.instr_ready;
      state_d        = state_q;
      pc_d           = pc_q;
      instr_d        = instr_q;
      fetch_err_d    = fetch_err_q | expired;
      misalign_err_d = misalign_err_q;
      retired_d      = retired_q;
      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = got_ack ? VALID : FETCH;
         VALID:   state_d = handshake ? FETCH : VALID;
         default: state_d = IDLE;
      endcase
      if (got_ack) instr_d = bus.imem_rdata;
      if (handshake) begin
         pc_d           = align_pc(pc_from_pcsel);
         misalign_err_d = misalign_err_q | (pc_from_pcsel[1:0] != 2'b00);
         retired_d      = retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         fetch_err_q    <= 1'b0;
         misalign_err_q <= 1'b0;
         retired_q      <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         fetch_err_q    <= fetch_err_d;
         misalign_err_q <= misalign_err_d;
         retired_q      <= retired_d;
      end
   end

   assign pc              = pc_q;
   assign pc_plus_4       = pc_q + 5'd4;
   assign pc_const        = pc_q + const_off;
   assign bus.imem_addr   = pc_q;
   assign bus.imem_req    = in_fetch;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = state_q == VALID;
   assign fetch_err       = fetch_err_q;
   assign misalign_err    = misalign_err_q;
   assign retired         = retired_q;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch.
module tb_pc_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  pc_from_pcsel, const_off, pc, pc_plus_4, pc_const;
   logic        fetch_err, misalign_err;
   logic [15:0] retired;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [4:0]  exp_pc;

   pc_fetch_if bus ();

   pc_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .pc_from_pcsel (pc_from_pcsel),
      .const_off     (const_off),
      .pc            (pc),
      .pc_plus_4     (pc_plus_4),
      .pc_const      (pc_const),
      .bus           (bus.master),
      .fetch_err     (fetch_err),
      .misalign_err  (misalign_err),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      pc_from_pcsel = '0;
      const_off = '0;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      bus.instr_ready = 1'b1;
      tick();
      tick();
      check("rst_pc", pc, 0);
      check("rst_valid", bus.instr_valid, 0);
      check("rst_req", bus.imem_req, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_ferr", fetch_err, 0);
      check("rst_merr", misalign_err, 0);
      check("rst_retired", retired, 0);

      // Zero-wait memory, ready always high, sequential PC
      rst = 1'b0;
      tick();
      check("lat_idle_valid", bus.instr_valid, 0);
      check("lat_req", bus.imem_req, 1);
      exp_pc = 5'd0;
      for (int i = 0; i < 8; i++) begin
         check("seq_addr", bus.imem_addr, exp_pc);
         if (exp_pc == 5'd28) check("pc4_wrap", pc_plus_4, 0);
         bus.imem_rdata = 32'hA000_0000 + i;
         tick();
         check("seq_valid", bus.instr_valid, 1);
         check("seq_instr", bus.instr, 32'hA000_0000 + i);
         pc_from_pcsel = exp_pc + 5'd4;
         tick();
         exp_pc = exp_pc + 5'd4;
      end
      check("seq_wrap_addr", bus.imem_addr, 0);
      check("seq_retired", retired, 8);

      // Ack delayed 3 cycles, then ready delayed 4 cycles
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ackwait_req", bus.imem_req, 1);
         check("ackwait_addr", bus.imem_addr, 0);
         check("ackwait_valid", bus.instr_valid, 0);
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h1234_5678;
      tick();
      check("ack_valid", bus.instr_valid, 1);
      for (int i = 0; i < 4; i++) begin
         bus.imem_rdata = 32'hFFFF_0000 + i;
         pc_from_pcsel = 5'd20;
         tick();
         check("rdywait_instr", bus.instr, 32'h1234_5678);
         check("rdywait_valid", bus.instr_valid, 1);
         check("rdywait_pc", pc, 0);
      end
      check("rdywait_retired", retired, 8);
      pc_from_pcsel = 5'd4;
      bus.instr_ready = 1'b1;
      tick();
      check("hs_pc", pc, 4);
      check("hs_retired", retired, 9);
      check("hs_req", bus.imem_req, 1);

      // Negative offset and misaligned next PC
      const_off = 5'b11000;
      bus.instr_ready = 1'b0;
      #1;
      check("pc_const_neg", pc_const, 28);
      tick();
      pc_from_pcsel = 5'd6;
      bus.instr_ready = 1'b1;
      tick();
      check("mis_pc", pc, 4);
      check("mis_err", misalign_err, 1);
      check("mis_retired", retired, 10);
      check("mis_pc4", pc_plus_4, 8);

      // Ack on the 15th wait cycle must win over the timeout
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h0BAD_F00D;
      tick();
      check("edge_ferr", fetch_err, 0);
      check("edge_valid", bus.instr_valid, 1);
      check("edge_instr", bus.instr, 32'h0BAD_F00D);
      pc_from_pcsel = 5'd8;
      bus.instr_ready = 1'b1;
      tick();
      check("edge_hs_pc", pc, 8);

      // 15 cycles without ack: timeout, reissue same address
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      check("to_pre_ferr", fetch_err, 0);
      tick();
      check("to_ferr", fetch_err, 1);
      check("to_req", bus.imem_req, 1);
      check("to_addr", bus.imem_addr, 8);
      check("to_valid", bus.instr_valid, 0);
      tick();
      bus.imem_ack = 1'b1;
      tick();
      check("to_ack_valid", bus.instr_valid, 1);
      check("to_sticky", fetch_err, 1);
      check("to_retired", retired, 11);

      // Reset during FETCH with a simultaneous ack
      pc_from_pcsel = 5'd12;
      bus.instr_ready = 1'b1;
      tick();
      check("pre_rst_pc", pc, 12);
      bus.instr_ready = 1'b0;
      bus.imem_rdata = 32'h5555_AAAA;
      rst = 1'b1;
      tick();
      check("mrst_pc", pc, 0);
      check("mrst_valid", bus.instr_valid, 0);
      check("mrst_retired", retired, 0);
      check("mrst_instr", bus.instr, 0);
      check("mrst_ferr", fetch_err, 0);
      check("mrst_merr", misalign_err, 0);
      rst = 1'b0;
      bus.imem_ack = 1'b0;
      tick();
      tick();
      check("mrst_drop_valid", bus.instr_valid, 0);
      check("mrst_drop_instr", bus.instr, 0);
      check("mrst_req", bus.imem_req, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
